// File: rtl/ready_valid_arb_pkg.sv
// Shared types and helpers for the round-robin ready/valid arbiter.
package ready_valid_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int RV_DATA_W = 8;

  // First set request strictly after `last`, with wrap, over n requesters (n <= 8).
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last,
                                         input int n);
    logic [2:0] pick;
    logic       hit;
    int         idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(last) + k) % n;
      if (!hit && k <= n && req[idx[2:0]]) begin
        pick = idx[2:0];
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ready_valid_arbiter_rr_pick.sv
// Combinational round-robin pick: next requesting index after last_grant.
module rr_pick
  import ready_valid_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int IW = $clog2(N_REQ);

  logic [7:0] req8;
  logic [2:0] last3;

  always_comb begin
    req8             = '0;
    req8[N_REQ-1:0]  = req;
    last3            = 3'(last);
    found            = |req;
    index            = IW'(rr_next(req8, last3, N_REQ));
  end

endmodule

// File: rtl/ready_valid_arbiter.sv
// Round-robin, burst-locked arbiter merging N_REQ byte streams onto one
// registered ready/valid output.
module ready_valid_arbiter
  import ready_valid_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*RV_DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]               req_ready,
  output logic                           out_valid,
  output logic [RV_DATA_W-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]       out_src,
  input  logic                           out_ready
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST) + 1;

  logic [N_REQ-1:0][RV_DATA_W-1:0] req_bytes;
  assign req_bytes = req_data;

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [RV_DATA_W-1:0]   out_data_q, out_data_d;
  logic [IW-1:0]          out_src_q, out_src_d;

  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic                   hold_rdy;
  logic                   accept;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    req_ready   = '0;
    accept      = 1'b0;
    // The single output slot can take a byte if empty or draining this cycle.
    hold_rdy    = !out_valid_q || out_ready;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_q] = hold_rdy;
        accept             = hold_rdy && req_valid[grant_q];
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BURST - 1)) state_d = IDLE;
        end else if (hold_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_bytes[grant_q];
      out_src_d   = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IW'(N_REQ - 1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/ready_valid_arbiter.md
# ready_valid_arbiter

Round-robin arbiter that shares one ready/valid byte channel between `N_REQ` independent ready/valid requesters. A byte transfers on any port in the cycle where both valid and ready are high. The block sits between several byte sources and the single downstream ready/valid sink that the verification agent drives and monitors. It adds burst locking so that each requester can transfer up to `BURST` consecutive bytes per grant. The output is fully registered: one-deep pipeline with back-pressure.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `BURST`, default 4: maximum bytes accepted per grant, range 1..16.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester valid.
- `req_data`  in  N_REQ×8  per-requester byte; requester i uses bits [8i+7:8i].
- `req_ready`  out  N_REQ  per-requester ready.
- `out_valid`  out  1  downstream valid (registered).
- `out_data`  out  8  downstream byte (registered).
- `out_src`  out  $clog2(N_REQ)  index of the requester that supplied `out_data` (registered).
- `out_ready`  in  1  downstream ready.

## Operation
- Reset values: state = IDLE, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `last_grant` = N_REQ-1, burst count = 0.
- Outputs during reset: `req_ready` = 0 in reset and in IDLE.
- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit scanning from `last_grant`+1 upward, with wrap.
  - Register that index as `grant`, set `last_grant` = `grant`, clear the count, and go to GRANT.
  - If no request is present, stay in IDLE.
- **GRANT**
  - `req_ready[grant]` = !`out_valid` | `out_ready`. All other `req_ready` bits are 0.
  - On an accept (`req_valid[grant]` & `req_ready[grant]`): load `out_data`/`out_src`, set `out_valid`, and increment the count.
  - Go to IDLE when either of these holds:
    - an accept occurs with count == BURST-1, or
    - `req_valid[grant]` is 0 in a cycle where `req_ready[grant]` is 1.
  - If the holder is back-pressured (`req_ready` = 0), the grant is held regardless of its valid.
- **Output register**
  - `out_valid` clears when `out_ready` = 1 and no new accept occurs in the same cycle.
  - A simultaneous drain and accept keeps `out_valid` = 1 with the new byte.
  - `out_data` and `out_src` stay stable while `out_valid` & !`out_ready`.
- Requesters must hold `req_data` stable while `req_valid` is high and unaccepted. The arbiter does not check this.
- Mid-operation reset: an asynchronous `rst_n` assertion returns the block to the reset values immediately. A byte held in the output register is dropped.

## Timing
- Arbitration costs 1 cycle: the first `req_ready` for a new grant appears the cycle after IDLE samples the request.
- Latency is 1 cycle from input accept to `out_valid`.
- Peak throughput is BURST bytes per BURST+1 cycles when several requesters are active. A single continuous requester gets the same rate, because it re-arbitrates after each burst.
- The count width is $clog2(BURST)+1. The count never exceeds BURST-1 on any accept.
- With BURST = 1, every accept returns the block to IDLE.
- A requester dropping valid costs one extra IDLE cycle before the next grant.

## Structure
- Shared package `ready_valid_arb_pkg` holds:
  - the state typedef `arb_state_t` {IDLE, GRANT},
  - the constant `RV_DATA_W` = 8,
  - the function `rr_next(req, last)` returning the round-robin index.
- One sub-module `rr_pick`: purely combinational, taking `N_REQ` request bits and `last_grant`, producing `found` and `index`. The main module instantiates it once in the IDLE path.
- Target size: 150–250 lines of RTL total.

## Test plan
- **Reset:** assert `rst_n` = 0 with all `req_valid` = 1 → `req_ready` = 0, `out_valid` = 0, `out_src` = 0. After release, the first grant goes to requester 0.
- **Round-robin, single bytes:** N_REQ = 4, BURST = 4, requesters 0–3 each present one byte (0x10, 0x21, 0x32, 0x43) and then drop valid; `out_ready` = 1 → out sequence 0x10/src0, 0x21/src1, 0x32/src2, 0x43/src3, with an IDLE cycle between grants.
- **Burst limit:** requesters 1 and 2 stream continuously → src pattern 1,1,1,1,2,2,2,2,1…, never 5 consecutive bytes from one src.
- **Back-pressure:** hold `out_ready` = 0 for 5 cycles after the first accept of 0xA5 → `out_data` stays 0xA5 and `req_ready` = 0 throughout. On release, the next byte follows with no loss or duplicate.
- **Simultaneous drain and accept:** `out_ready` = 1 with continuous input → `out_valid` stays 1 for BURST consecutive cycles, with data incrementing 0x00..0x03.
- **Reset mid-burst:** pulse `rst_n` low after 2 of 4 bytes → outputs return to reset values at once. The next grant starts from requester 0 with a fresh count of 4.
